// File: rtl/packet_fifo_pkg.sv
// Shared types and sizing helpers for the FX2 sample packet buffer.
package packet_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READY   = 2'd1,
    READING = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_PACKET_WORDS = 256;
  localparam int DEF_DEPTH        = 1024;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int count_width(input int packet_words);
    return $clog2(packet_words + 1);
  endfunction

endpackage

// File: rtl/packet_fifo_if.sv
// Sample-in / FX2-out handshake bundle of the packet buffer.
interface packet_fifo_if
  import packet_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) ();

  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic                          rd_req;
  logic                          packet_rdy;
  logic [DATA_WIDTH-1:0]         dout;
  logic                          dout_valid;
  logic [level_width(DEPTH)-1:0] level;
  logic                          overflow;

  modport master (
    output wr_en, wr_data, rd_req,
    input  packet_rdy, dout, dout_valid, level, overflow
  );

  modport slave (
    input  wr_en, wr_data, rd_req,
    output packet_rdy, dout, dout_valid, level, overflow
  );

endinterface

// File: rtl/packet_ram.sv
// Simple dual-port RAM with registered read data; no reset so it maps to block RAM.
module packet_ram
  import packet_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [ptr_width(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        rd_en,
  input  logic [ptr_width(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]       rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/packet_fifo.sv
// Circular sample buffer that releases one PACKET_WORDS packet per FX2 read burst.
module packet_fifo
  import packet_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int PACKET_WORDS = DEF_PACKET_WORDS,
  parameter int DEPTH        = DEF_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  packet_fifo_if.slave bus
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int LVL_W = level_width(DEPTH);
  localparam int CNT_W = count_width(PACKET_WORDS);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] PKT_LVL  = LVL_W'(PACKET_WORDS);
  localparam logic [CNT_W-1:0] PKT_CNT  = CNT_W'(PACKET_WORDS);

  state_t                state;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level_q;
  logic [CNT_W-1:0]      rd_cnt;
  logic [CNT_W-1:0]      rd_cnt_inc;
  logic                  overflow_q;
  logic                  pop;
  logic                  wr_accept;
  logic                  vld_p1;
  logic                  live_p1;
  logic [DATA_WIDTH-1:0] ram_q_p1;

  // A simultaneous pop frees a slot, so a write to a full RAM still lands.
  assign pop        = bus.rd_req && (state != IDLE);
  assign wr_accept  = bus.wr_en && ((level_q != FULL_LVL) || pop);
  assign rd_cnt_inc = rd_cnt + 1'b1;

  packet_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (bus.wr_data),
    .rd_en   (pop),
    .rd_addr (rd_ptr),
    .rd_data (ram_q_p1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      rd_cnt     <= '0;
      overflow_q <= 1'b0;
      vld_p1     <= 1'b0;
      live_p1    <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      if (wr_accept && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !wr_accept) begin
        level_q <= level_q - 1'b1;
      end

      if (bus.wr_en && !wr_accept) begin
        overflow_q <= 1'b1;
      end

      // ---- read stage p1: RAM output register becomes dout ----
      vld_p1 <= pop;
      if (pop) begin
        live_p1 <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (level_q >= PKT_LVL) begin
            state <= READY;
          end
        end
        READY, READING: begin
          if (pop) begin
            if (rd_cnt_inc == PKT_CNT) begin
              state  <= IDLE;
              rd_cnt <= '0;
            end else begin
              state  <= READING;
              rd_cnt <= rd_cnt_inc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The RAM register has no reset; dout reads as zero until the first pop after reset.
  assign bus.dout       = live_p1 ? ram_q_p1 : '0;
  assign bus.dout_valid = vld_p1;
  assign bus.packet_rdy = (state == READY);
  assign bus.level      = level_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_packet_fifo.sv
// Directed bench for packet_fifo: packet framing, latency, overflow and reset behaviour.
module tb_packet_fifo;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  packet_fifo_if #(.DATA_WIDTH(16), .DEPTH(1024)) bus ();

  packet_fifo #(
    .DATA_WIDTH   (16),
    .PACKET_WORDS (256),
    .DEPTH        (1024)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.rd_req  = 1'b0;
    bus.wr_data = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 16'(base + i);
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  // Holds rd_req high and checks n consecutive valid words starting at base.
  task automatic drain(input string tag, input int n, input int base, input int budget);
    int got;
    got = 0;
    bus.rd_req = 1'b1;
    for (int c = 0; c < budget && got < n; c++) begin
      tick();
      if (bus.dout_valid) begin
        check(tag, 32'(bus.dout), 32'(16'(base + got)));
        got++;
      end
    end
    bus.rd_req = 1'b0;
    check({tag, "_count"}, 32'(got), 32'(n));
  endtask

  initial begin
    int   exp_w;
    int   rises;
    logic prev_rdy;

    bus.wr_en   = 1'b0;
    bus.rd_req  = 1'b0;
    bus.wr_data = '0;
    reset       = 1'b1;

    // Reset state
    do_reset();
    check("rst_packet_rdy", 32'(bus.packet_rdy), 0);
    check("rst_dout",       32'(bus.dout), 0);
    check("rst_dout_valid", 32'(bus.dout_valid), 0);
    check("rst_level",      32'(bus.level), 0);
    check("rst_overflow",   32'(bus.overflow), 0);

    // Single packet: rdy 2 cycles after last write, 256 words then 2 ignored requests
    write_n(256, 0);
    check("single_level_256", 32'(bus.level), 256);
    check("single_rdy_lag1",  32'(bus.packet_rdy), 0);
    tick();
    check("single_rdy_lag2",  32'(bus.packet_rdy), 1);
    bus.rd_req = 1'b1;
    for (int k = 0; k < 258; k++) begin
      tick();
      if (k == 0) check("single_rdy_fall", 32'(bus.packet_rdy), 0);
      if (k < 256) begin
        check("single_valid", 32'(bus.dout_valid), 1);
        check("single_dout",  32'(bus.dout), 32'(k));
      end else begin
        check("single_trail_valid", 32'(bus.dout_valid), 0);
        check("single_trail_hold",  32'(bus.dout), 255);
      end
    end
    bus.rd_req = 1'b0;
    check("single_level_end", 32'(bus.level), 0);
    check("single_overflow",  32'(bus.overflow), 0);
    check("single_rdy_end",   32'(bus.packet_rdy), 0);

    // Early reads are ignored while below one packet
    do_reset();
    write_n(200, 1000);
    tick();
    bus.rd_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("early_valid", 32'(bus.dout_valid), 0);
      check("early_rdy",   32'(bus.packet_rdy), 0);
    end
    bus.rd_req = 1'b0;
    check("early_level", 32'(bus.level), 200);

    // Back-to-back packets with concurrent streaming writes
    do_reset();
    exp_w      = 0;
    rises      = 0;
    prev_rdy   = 1'b0;
    bus.rd_req = 1'b1;
    for (int c = 0; c < 1500 && exp_w < 768; c++) begin
      bus.wr_en   = (c < 768);
      bus.wr_data = 16'(c);
      tick();
      if (bus.dout_valid) begin
        check("b2b_dout", 32'(bus.dout), 32'(exp_w));
        exp_w++;
      end
      if (bus.packet_rdy && !prev_rdy) begin
        rises++;
        check("b2b_rdy_on_boundary", 32'(exp_w % 256), 0);
      end
      prev_rdy = bus.packet_rdy;
    end
    bus.wr_en  = 1'b0;
    bus.rd_req = 1'b0;
    check("b2b_words",   32'(exp_w), 768);
    check("b2b_packets", 32'(rises), 3);
    check("b2b_level",   32'(bus.level), 0);

    // Overflow: 1030 writes keep the first 1024 and set the sticky flag
    do_reset();
    write_n(1030, 0);
    check("ovf_level", 32'(bus.level), 1024);
    check("ovf_flag",  32'(bus.overflow), 1);
    drain("ovf_rd", 1024, 0, 1200);
    check("ovf_flag_sticky", 32'(bus.overflow), 1);
    check("ovf_level_end",   32'(bus.level), 0);

    // Full RAM with simultaneous pop and write
    do_reset();
    write_n(1024, 2000);
    tick();
    check("full_level",    32'(bus.level), 1024);
    check("full_overflow", 32'(bus.overflow), 0);
    check("full_rdy",      32'(bus.packet_rdy), 1);
    bus.rd_req  = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'hABCD;
    tick();
    bus.wr_en = 1'b0;
    check("fullpop_level",    32'(bus.level), 1024);
    check("fullpop_overflow", 32'(bus.overflow), 0);
    check("fullpop_valid",    32'(bus.dout_valid), 1);
    check("fullpop_dout",     32'(bus.dout), 2000);
    drain("fullpop_rd", 1023, 2001, 1200);
    check("fullpop_level_end", 32'(bus.level), 1);
    check("fullpop_ovf_end",   32'(bus.overflow), 0);

    // Reset in the middle of a packet
    do_reset();
    write_n(256, 500);
    tick();
    drain("midrst_pre", 100, 500, 200);
    reset      = 1'b1;
    bus.rd_req = 1'b1;
    tick();
    check("midrst_rdy",   32'(bus.packet_rdy), 0);
    check("midrst_valid", 32'(bus.dout_valid), 0);
    check("midrst_level", 32'(bus.level), 0);
    check("midrst_dout",  32'(bus.dout), 0);
    reset      = 1'b0;
    tick();
    bus.rd_req = 1'b0;
    check("midrst_idle_rdy",   32'(bus.packet_rdy), 0);
    check("midrst_idle_level", 32'(bus.level), 0);
    write_n(256, 7000);
    tick();
    check("midrst_new_rdy", 32'(bus.packet_rdy), 1);
    drain("midrst_post", 256, 7000, 400);
    check("midrst_new_level", 32'(bus.level), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
